// File: rtl/ghost_collision.sv
// rtl/ghost_collision.sv - Yoshi/bottom-ghost collision, lives, invulnerability and game-over control
// Pixel overlap is latched during the frame and confirmed by a bounding-box test on frame_tick.
module ghost_collision #(
    parameter int SPRITE_W      = 16,
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_CYCLES = 50_000_000,
    parameter int TIMER_W       = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       restart,
    input  logic [9:0] y_x,
    input  logic [9:0] y_y,
    input  logic [9:0] g_b_x,
    input  logic [9:0] g_b_y,
    input  logic       yoshi_on,
    input  logic       ghost_bottom_on,
    output logic       hit,
    output logic       ghost_respawn,
    output logic [2:0] lives,
    output logic       invuln,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_INVULN = 2'd1,
        ST_OVER   = 2'd2
    } state_t;

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(INVULN_CYCLES - 1);
    localparam logic [2:0]         LIVES_RST  = 3'(LIVES_INIT);
    localparam logic [10:0]        SPRITE_LIM = 11'(SPRITE_W);

    state_t               state_q, state_d;
    logic [2:0]           lives_q, lives_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 ov_flag_q, ov_flag_d;
    logic                 hit_q, hit_d;
    logic                 invuln_q, invuln_d;
    logic                 game_over_q, game_over_d;

    logic [10:0]          dx, dy;
    logic                 overlap, box, collision;

    // Widened to 11 bits so the absolute difference never wraps.
    always_comb begin
        dx = (y_x >= g_b_x) ? ({1'b0, y_x} - {1'b0, g_b_x}) : ({1'b0, g_b_x} - {1'b0, y_x});
        dy = (y_y >= g_b_y) ? ({1'b0, y_y} - {1'b0, g_b_y}) : ({1'b0, g_b_y} - {1'b0, y_y});
    end

    assign overlap   = yoshi_on & ghost_bottom_on;
    assign box       = (dx < SPRITE_LIM) && (dy < SPRITE_LIM);
    assign collision = frame_tick & ov_flag_q & box;

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        timer_d     = timer_q;
        hit_d       = 1'b0;
        // An overlap on the tick cycle counts toward the following frame.
        ov_flag_d   = frame_tick ? overlap : (ov_flag_q | overlap);

        if (restart) begin
            state_d   = ST_PLAY;
            lives_d   = LIVES_RST;
            timer_d   = '0;
            ov_flag_d = 1'b0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (collision) begin
                        hit_d = 1'b1;
                        if (lives_q > 3'd1) begin
                            lives_d = lives_q - 3'd1;
                            timer_d = TIMER_LOAD;
                            state_d = ST_INVULN;
                        end else begin
                            lives_d = 3'd0;
                            state_d = ST_OVER;
                        end
                    end
                end
                ST_INVULN: begin
                    if (timer_q == '0) begin
                        state_d = ST_PLAY;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_PLAY;
                end
            endcase
        end

        invuln_d    = (state_d == ST_INVULN);
        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PLAY;
            lives_q     <= LIVES_RST;
            timer_q     <= '0;
            ov_flag_q   <= 1'b0;
            hit_q       <= 1'b0;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            timer_q     <= timer_d;
            ov_flag_q   <= ov_flag_d;
            hit_q       <= hit_d;
            invuln_q    <= invuln_d;
            game_over_q <= game_over_d;
        end
    end

    assign hit           = hit_q;
    assign ghost_respawn = hit_q;
    assign lives         = lives_q;
    assign invuln        = invuln_q;
    assign game_over     = game_over_q;

endmodule
